// File: rtl/modinv_helper_invert_update_pkg.sv
// Shared constants for the inversion-loop update stage; the controller imports
// these to know the update latency and the counter windows.
package modinv_helper_invert_update_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  function automatic int proc_num_cycles(input int num_words);
    return num_words + 4;
  endfunction

  // Counter values at which each pipeline stage starts or stops.
  localparam int RD_STEP_FIRST_CNT = 1;
  localparam int BORROW_MASK_CNT   = 2;
  localparam int WR_START_CNT      = 4;

  function automatic int rd_step_last_cnt(input int num_words);
    return num_words - 1;
  endfunction

  function automatic int err_latch_cnt(input int num_words);
    return num_words + 2;
  endfunction

  function automatic int wr_stop_cnt(input int num_words);
    return num_words + 3;
  endfunction

endpackage

// File: rtl/subtractor32_wrapper.sv
// 32-bit subtractor with borrow in/out; difference and borrow are registered.
module subtractor32_wrapper (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        b_in,
  output logic [31:0] d,
  output logic        b_out
);

  logic [32:0] diff;

  assign diff = {1'b0, a} - {1'b0, b} - {32'd0, b_in};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d     <= '0;
      b_out <= 1'b0;
    end else begin
      d     <= diff[31:0];
      b_out <= diff[32];
    end
  end

endmodule

// File: rtl/modinv_helper_invert_update.sv
// Word-serial a := a >> 1 or a := (a - b) >> 1 over BUFFER_NUM_WORDS words,
// streamed LSW-first with the right shift fused into the write-back.
module modinv_helper_invert_update
  import modinv_helper_invert_update_pkg::*;
#(
  parameter int BUFFER_NUM_WORDS = 9,
  parameter int BUFFER_ADDR_BITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  output logic                        rdy,
  input  logic                        sub_en,
  output logic [BUFFER_ADDR_BITS-1:0] a_addr,
  output logic [BUFFER_ADDR_BITS-1:0] b_addr,
  input  logic [31:0]                 a_din,
  input  logic [31:0]                 b_din,
  output logic [BUFFER_ADDR_BITS-1:0] out_addr,
  output logic                        out_wren,
  output logic [31:0]                 out_dout,
  output logic                        err
);

  localparam int PROC_NUM_CYCLES = proc_num_cycles(BUFFER_NUM_WORDS);
  localparam int CNT_BITS        = clog2(PROC_NUM_CYCLES);

  localparam logic [CNT_BITS-1:0] CNT_LAST     = CNT_BITS'(PROC_NUM_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_RD_FIRST = CNT_BITS'(RD_STEP_FIRST_CNT);
  localparam logic [CNT_BITS-1:0] CNT_RD_LAST  = CNT_BITS'(rd_step_last_cnt(BUFFER_NUM_WORDS));
  localparam logic [CNT_BITS-1:0] CNT_MASK     = CNT_BITS'(BORROW_MASK_CNT);
  localparam logic [CNT_BITS-1:0] CNT_ERR      = CNT_BITS'(err_latch_cnt(BUFFER_NUM_WORDS));
  localparam logic [CNT_BITS-1:0] CNT_WR_FIRST = CNT_BITS'(WR_START_CNT);
  localparam logic [CNT_BITS-1:0] CNT_WR_LAST  = CNT_BITS'(wr_stop_cnt(BUFFER_NUM_WORDS));

  logic [CNT_BITS-1:0] proc_cnt;
  logic                start;
  logic                sub_en_r;
  logic [31:0]         b_word;
  logic                sub_b_in;
  logic [31:0]         d;
  logic                sub_b_out;
  logic [31:0]         d_prev;
  logic [CNT_BITS-1:0] wr_idx;

  assign rdy   = (proc_cnt == '0);
  assign start = rdy && ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_cnt <= '0;
    end else if (!rdy || ena) begin
      proc_cnt <= (proc_cnt == CNT_LAST) ? '0 : proc_cnt + CNT_BITS'(1);
    end
  end

  // err clears on start and then captures the borrow out of the top word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_en_r <= 1'b0;
      err      <= 1'b0;
    end else if (start) begin
      sub_en_r <= sub_en;
      err      <= 1'b0;
    end else if (proc_cnt == CNT_ERR) begin
      err <= sub_b_out;
    end
  end

  // Address parks at the top word after the last read and returns to 0 on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_addr <= '0;
    end else if (rdy || proc_cnt == CNT_LAST) begin
      a_addr <= '0;
    end else if (proc_cnt >= CNT_RD_FIRST && proc_cnt <= CNT_RD_LAST) begin
      a_addr <= a_addr + BUFFER_ADDR_BITS'(1);
    end
  end

  assign b_addr   = a_addr;
  assign b_word   = sub_en_r ? b_din : 32'd0;
  assign sub_b_in = (proc_cnt == CNT_MASK) ? 1'b0 : sub_b_out;

  subtractor32_wrapper u_sub (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a_din),
    .b     (b_word),
    .b_in  (sub_b_in),
    .d     (d),
    .b_out (sub_b_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_prev <= '0;
    end else begin
      d_prev <= d;
    end
  end

  assign wr_idx = proc_cnt - CNT_WR_FIRST;

  // Outputs decode straight from proc_cnt so a reset drops out_wren at once.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    out_wren = 1'b0;
    out_addr = '0;
    out_dout = '0;
    if (proc_cnt >= CNT_WR_FIRST && proc_cnt <= CNT_WR_LAST) begin
      out_wren = 1'b1;
      out_addr = BUFFER_ADDR_BITS'(wr_idx);
      if (proc_cnt == CNT_WR_LAST) begin
        out_dout = {1'b0, d_prev[31:1]};
      end else begin
        out_dout = {d[0], d_prev[31:1]};
      end
    end
  end

endmodule
